// File: rtl/os_feed_pkg.sv
// Shared types and helpers for the operand skewer.
// Stream-length and counter-width math lives here.
package os_feed_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DONE
  } feed_state_e;

  // Slices needed to drain a K-deep operand
  // through the farthest skewed lane.
  function automatic int stream_len(
    input int k,
    input int rows,
    input int cols
  );
    return k + ((rows > cols) ? rows : cols) - 1;
  endfunction

  function automatic int cnt_width(input int t);
    return $clog2(t) + 1;
  endfunction

  localparam int CNT_W_DEF =
    cnt_width(stream_len(4, 4, 4));

endpackage

// File: rtl/os_skew_lane.sv
// One skewed lane: picks word k = t - IDX from a
// K-word vector. Ports: vec, t, active, gate -> word, valid.
module os_skew_lane #(
  parameter int K   = 4,
  parameter int W   = 16,
  parameter int IDX = 0,
  parameter int CW  = 4
) (
  input  logic [K*W-1:0] vec,
  input  logic [CW-1:0]  t,
  input  logic           active,
  input  logic           gate,
  output logic [W-1:0]   word,
  output logic           valid
);

  // The lane is delayed by IDX slices, so slice t
  // carries element t-IDX while that index is in range.
  always_comb begin
    word  = '0;
    valid = 1'b0;
    if (active) begin
      for (int k = 0; k < K; k++) begin
        if (t == CW'(IDX + k)) begin
          word  = vec[k*W +: W];
          valid = gate;
        end
      end
    end
  end

endmodule

// File: rtl/os_operand_skewer.sv
// Buffers one operand pair and streams it diagonally
// into the array edges. Ports: load handshake, stall,
// per-lane words/valids, busy, feed_done.
module os_operand_skewer
  import os_feed_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int K         = 4,
  parameter int WORD_SIZE = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [ROWS*K*WORD_SIZE-1:0] left_matrix,
  input  logic [K*COLS*WORD_SIZE-1:0] top_matrix,
  input  logic                        stall,
  output logic [ROWS*WORD_SIZE-1:0]   left_out,
  output logic [ROWS-1:0]             left_valid,
  output logic [COLS*WORD_SIZE-1:0]   top_out,
  output logic [COLS-1:0]             top_valid,
  output logic                        busy,
  output logic                        feed_done
);

  localparam int W  = WORD_SIZE;
  localparam int T  = stream_len(K, ROWS, COLS);
  localparam int CW = cnt_width(T);
  localparam logic [CW-1:0] LAST = CW'(T - 1);

  feed_state_e             state;
  logic [CW-1:0]           cnt;
  logic [ROWS*K*W-1:0]     left_buf;
  logic [K*COLS*W-1:0]     top_buf;
  logic                    feeding;
  logic                    gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            left_buf <= left_matrix;
            top_buf  <= top_matrix;
            cnt      <= '0;
            state    <= FEED;
          end
        end
        FEED: begin
          if (!stall) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign feed_done  = (state == DONE);
  assign feeding    = (state == FEED);
  // Stall keeps the words on the bus but withdraws valids.
  assign gate       = !stall;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    os_skew_lane #(
      .K(K), .W(W), .IDX(r), .CW(CW)
    ) u_lane (
      .vec    (left_buf[r*K*W +: K*W]),
      .t      (cnt),
      .active (feeding),
      .gate   (gate),
      .word   (left_out[r*W +: W]),
      .valid  (left_valid[r])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [K*W-1:0] col_vec;
    // Gather column c out of the row-major top buffer.
    for (genvar k = 0; k < K; k++) begin : g_k
      assign col_vec[k*W +: W] =
        top_buf[(k*COLS + c)*W +: W];
    end
    os_skew_lane #(
      .K(K), .W(W), .IDX(c), .CW(CW)
    ) u_lane (
      .vec    (col_vec),
      .t      (cnt),
      .active (feeding),
      .gate   (gate),
      .word   (top_out[c*W +: W]),
      .valid  (top_valid[c])
    );
  end

endmodule
